// File: rtl/alu_issue.sv
// Decode/issue stage for the integer ALU: decodes OP, OP-IMM, LUI and AUIPC
// into op code and operands, held in one valid/ready output slot.
module alu_issue #(
    parameter int XLEN = 32,
    parameter int OPW  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OPW-1:0]  alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic            illegal,
    output logic [31:0]     issue_cnt
);

    localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(3);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(4);
    localparam logic [OPW-1:0] OP_SLTU = OPW'(5);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(6);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(7);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(8);
    localparam logic [OPW-1:0] OP_OR   = OPW'(9);
    localparam logic [OPW-1:0] OP_AND  = OPW'(10);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic [OPW-1:0]  w_op;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_dec;
    logic            w_ill;
    logic            w_we;
    logic            w_accept;
    logic            w_handshake;
    logic            w_unused_rs;

    logic            r_valid;
    logic [OPW-1:0]  r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [4:0]      r_rd;
    logic            r_we;
    logic            r_ill;
    logic [31:0]     r_cnt;

    assign w_opcode    = instr[6:0];
    assign w_f3        = instr[14:12];
    assign w_f7        = instr[31:25];
    assign w_rd        = instr[11:7];
    assign w_imm_i     = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign w_imm_u     = {instr[31:12], 12'b0};
    assign w_unused_rs = ^instr[19:15];

    always_comb begin
        w_op  = OP_NOP;
        w_a   = '0;
        w_b   = '0;
        w_dec = 1'b0;
        w_ill = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_dec = 1'b1;
                w_a   = rs1_data;
                w_b   = rs2_data;
                // The ALU shifts by all of data2, so present only the 5-bit amount
                if (w_f3 == 3'b001 || w_f3 == 3'b101)
                    w_b = {{(XLEN-5){1'b0}}, rs2_data[4:0]};
                if (w_f7 == F7_BASE ||
                    (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
                    case (w_f3)
                        3'b000:  w_op = w_f7[5] ? OP_SUB : OP_ADD;
                        3'b001:  w_op = OP_SLL;
                        3'b010:  w_op = OP_SLT;
                        3'b011:  w_op = OP_SLTU;
                        3'b100:  w_op = OP_XOR;
                        3'b101:  w_op = w_f7[5] ? OP_SRA : OP_SRL;
                        3'b110:  w_op = OP_OR;
                        default: w_op = OP_AND;
                    endcase
                end else begin
                    w_ill = 1'b1;
                end
            end
            OPC_OPIMM: begin
                w_dec = 1'b1;
                w_a   = rs1_data;
                w_b   = w_imm_i;
                case (w_f3)
                    3'b000: w_op = OP_ADD;
                    3'b001: begin
                        w_b = {{(XLEN-5){1'b0}}, instr[24:20]};
                        if (w_f7 == F7_BASE) w_op = OP_SLL;
                        else                 w_ill = 1'b1;
                    end
                    3'b010: w_op = OP_SLT;
                    3'b011: w_op = OP_SLTU;
                    3'b100: w_op = OP_XOR;
                    3'b101: begin
                        w_b = {{(XLEN-5){1'b0}}, instr[24:20]};
                        if (w_f7 == F7_BASE)     w_op = OP_SRL;
                        else if (w_f7 == F7_ALT) w_op = OP_SRA;
                        else                     w_ill = 1'b1;
                    end
                    3'b110:  w_op = OP_OR;
                    default: w_op = OP_AND;
                endcase
            end
            OPC_LUI: begin
                w_dec = 1'b1;
                w_op  = OP_ADD;
                w_b   = w_imm_u;
            end
            OPC_AUIPC: begin
                w_dec = 1'b1;
                w_op  = OP_ADD;
                w_a   = pc;
                w_b   = w_imm_u;
            end
            default: ;
        endcase
    end

    assign w_we        = w_dec && !w_ill && (w_rd != 5'd0);
    assign in_ready    = !flush && (!r_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_handshake = r_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_op    <= OP_NOP;
            r_a     <= '0;
            r_b     <= '0;
            r_rd    <= 5'd0;
            r_we    <= 1'b0;
            r_ill   <= 1'b0;
            r_cnt   <= 32'd0;
        end else begin
            if (w_handshake)
                r_cnt <= r_cnt + 32'd1;
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
                r_op    <= w_op;
                r_a     <= w_a;
                r_b     <= w_b;
                r_rd    <= w_rd;
                r_we    <= w_we;
                r_ill   <= w_ill;
            end else if (w_handshake) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign alu_op    = r_op;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign rd        = r_rd;
    assign rd_we     = r_we;
    assign illegal   = r_ill;
    assign issue_cnt = r_cnt;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode table, stall/back-to-back, flush and reset.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
    logic [31:0] issue_cnt;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_cnt;

    alu_issue #(.XLEN(32), .OPW(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .rd(rd),
        .rd_we(rd_we), .illegal(illegal), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  op;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
        logic        ab;
    } vec_t;

    // {out_valid, alu_op, alu_a, alu_b, rd, rd_we, illegal}
    function automatic logic [79:0] slot();
        return {out_valid, alu_op, alu_a, alu_b, rd, rd_we, illegal};
    endfunction

    function automatic logic [79:0] mk(input logic v, input logic [7:0] op,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] r, input logic we,
                                        input logic ill);
        return {v, op, a, b, r, we, ill};
    endfunction

    function automatic logic [31:0] addi_x(input int k);
        logic [31:0] v;
        v = 32'h13;
        v[31:20] = 12'(k);
        v[11:7]  = 5'(k);
        return v;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        instr    = ins;
        rs1_data = a;
        rs2_data = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (slot() !== 80'd0 || issue_cnt !== 32'd0) begin
            fails++;
            $display("FAIL reset_state got slot=%h cnt=%h want 0", slot(), issue_cnt);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 32'd0;
    endtask

    task automatic test_decode();
        vec_t        vt[20];
        logic [79:0] m;
        logic [79:0] e;
        vt[0]  = '{32'h00500093, 32'h0,        32'h0,        8'd1,  32'h0,        32'h5,        5'd1,  1'b1, 1'b0, 1'b1};
        vt[1]  = '{32'h402081B3, 32'd10,       32'd3,        8'd2,  32'd10,       32'd3,        5'd3,  1'b1, 1'b0, 1'b1};
        vt[2]  = '{32'h40435293, 32'h80000000, 32'h0,        8'd8,  32'h80000000, 32'd4,        5'd5,  1'b1, 1'b0, 1'b1};
        vt[3]  = '{32'h00209233, 32'd7,        32'h23,       8'd3,  32'd7,        32'h3,        5'd4,  1'b1, 1'b0, 1'b1};
        vt[4]  = '{32'h123453B7, 32'hDEAD,     32'hBEEF,     8'd1,  32'h0,        32'h12345000, 5'd7,  1'b1, 1'b0, 1'b1};
        vt[5]  = '{32'h00001417, 32'd5,        32'd6,        8'd1,  32'h1000,     32'h1000,     5'd8,  1'b1, 1'b0, 1'b1};
        vt[6]  = '{32'h02208133, 32'd6,        32'd7,        8'd0,  32'h0,        32'h0,        5'd2,  1'b0, 1'b1, 1'b0};
        vt[7]  = '{32'h00208033, 32'd1,        32'd2,        8'd1,  32'd1,        32'd2,        5'd0,  1'b0, 1'b0, 1'b1};
        vt[8]  = '{32'hFFF0B493, 32'd3,        32'd0,        8'd5,  32'd3,        32'hFFFFFFFF, 5'd9,  1'b1, 1'b0, 1'b1};
        vt[9]  = '{32'h4020D533, 32'd1,        32'hFFFFFFE4, 8'd8,  32'd1,        32'd4,        5'd10, 1'b1, 1'b0, 1'b1};
        vt[10] = '{32'h40109093, 32'd1,        32'd1,        8'd0,  32'h0,        32'h0,        5'd1,  1'b0, 1'b1, 1'b0};
        vt[11] = '{32'h0210D093, 32'd1,        32'd1,        8'd0,  32'h0,        32'h0,        5'd1,  1'b0, 1'b1, 1'b0};
        vt[12] = '{32'h4020B0B3, 32'd1,        32'd1,        8'd0,  32'h0,        32'h0,        5'd1,  1'b0, 1'b1, 1'b0};
        vt[13] = '{32'h0000A083, 32'd1,        32'd1,        8'd0,  32'h0,        32'h0,        5'd1,  1'b0, 1'b0, 1'b0};
        vt[14] = '{32'h8000C593, 32'h0F0F0F0F, 32'd0,        8'd6,  32'h0F0F0F0F, 32'hFFFFF800, 5'd11, 1'b1, 1'b0, 1'b1};
        vt[15] = '{32'h0020E633, 32'd5,        32'd9,        8'd9,  32'd5,        32'd9,        5'd12, 1'b1, 1'b0, 1'b1};
        vt[16] = '{32'h0020F6B3, 32'hF0,       32'h3C,       8'd10, 32'hF0,       32'h3C,       5'd13, 1'b1, 1'b0, 1'b1};
        vt[17] = '{32'h01F0D713, 32'h80000000, 32'd0,        8'd7,  32'h80000000, 32'd31,       5'd14, 1'b1, 1'b0, 1'b1};
        vt[18] = '{32'h0020A7B3, 32'hFFFFFFFF, 32'd1,        8'd4,  32'hFFFFFFFF, 32'd1,        5'd15, 1'b1, 1'b0, 1'b1};
        vt[19] = '{32'h0020C833, 32'hAAAA5555, 32'h0000FFFF, 8'd6,  32'hAAAA5555, 32'h0000FFFF, 5'd16, 1'b1, 1'b0, 1'b1};
        out_ready = 1'b1;
        pc        = 32'h1000;
        for (int i = 0; i < 20; i++) begin
            drive(vt[i].ins, vt[i].a, vt[i].b);
            m = vt[i].ab ? {80{1'b1}} : {9'h1FF, 64'h0, 7'h7F};
            e = mk(1'b1, vt[i].op, vt[i].ea, vt[i].eb, vt[i].rd, vt[i].we, vt[i].ill);
            tests++;
            if ((slot() & m) !== (e & m)) begin
                fails++;
                $display("FAIL decode[%0d] instr=%h got %h want %h", i, vt[i].ins, slot() & m, e & m);
            end
            @(posedge clk);
            #1;
            exp_cnt++;
            tests++;
            if (issue_cnt !== exp_cnt || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL handshake[%0d] got cnt=%0d valid=%b want cnt=%0d valid=0",
                         i, issue_cnt, out_valid, exp_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        base      = exp_cnt;
        rs1_data  = 32'd0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        instr    = addi_x(1);
        @(posedge clk);
        #1;
        @(negedge clk);
        instr = addi_x(2);
        @(posedge clk);
        #1;
        exp_cnt++;
        @(negedge clk);
        instr     = addi_x(3);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_in_ready[%0d] got %b want 0", i, in_ready);
            end
            @(posedge clk);
            #1;
            tests++;
            if (slot() !== mk(1'b1, 8'd1, 32'd0, 32'd2, 5'd2, 1'b1, 1'b0) || issue_cnt !== exp_cnt) begin
                fails++;
                $display("FAIL stall_frozen[%0d] got %h cnt=%0d want rd=2 op held cnt=%0d",
                         i, slot(), issue_cnt, exp_cnt);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL release_in_ready got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        exp_cnt++;
        tests++;
        if (slot() !== mk(1'b1, 8'd1, 32'd0, 32'd3, 5'd3, 1'b1, 1'b0)) begin
            fails++;
            $display("FAIL b2b_op3 got %h want rd=3 b=3", slot());
        end
        @(negedge clk);
        instr = addi_x(4);
        @(posedge clk);
        #1;
        exp_cnt++;
        tests++;
        if (slot() !== mk(1'b1, 8'd1, 32'd0, 32'd4, 5'd4, 1'b1, 1'b0)) begin
            fails++;
            $display("FAIL b2b_op4 got %h want rd=4 b=4", slot());
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_cnt++;
        tests++;
        if (out_valid !== 1'b0 || issue_cnt !== exp_cnt || issue_cnt - base !== 32'd4) begin
            fails++;
            $display("FAIL b2b_count got valid=%b cnt=%0d want valid=0 cnt=%0d",
                     out_valid, issue_cnt, base + 32'd4);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(addi_x(5), 32'd0, 32'd0);
        tests++;
        if (out_valid !== 1'b1 || rd !== 5'd5) begin
            fails++;
            $display("FAIL flush_setup got valid=%b rd=%0d want 1/5", out_valid, rd);
        end
        @(negedge clk);
        flush     = 1'b1;
        in_valid  = 1'b1;
        instr     = addi_x(6);
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_in_ready got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || issue_cnt !== exp_cnt) begin
            fails++;
            $display("FAIL flush_kill got valid=%b cnt=%0d want 0/%0d", out_valid, issue_cnt, exp_cnt);
        end
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || issue_cnt !== exp_cnt) begin
            fails++;
            $display("FAIL flush_no_accept got valid=%b cnt=%0d want 0/%0d", out_valid, issue_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        drive(32'h402081B3, 32'd10, 32'd3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 32'd0;
        tests++;
        if (slot() !== 80'd0 || issue_cnt !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid_stall got slot=%h cnt=%0d want 0", slot(), issue_cnt);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || issue_cnt !== 32'd0) begin
            fails++;
            $display("FAIL reset_release got valid=%b cnt=%0d want 0/0", out_valid, issue_cnt);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        instr     = 32'h0;
        pc        = 32'h0;
        rs1_data  = 32'h0;
        rs2_data  = 32'h0;
        exp_cnt   = 32'd0;
        #12;
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
